ram_unit: RTL

RAM_UNIT -- requirements
Module: ram_unit

---
 rtl/ram_unit_pkg.sv | 13 +
 rtl/ram_loader_fsm.sv | 86 ++++++++
 rtl/ram_unit.sv | 71 +++++++
 3 files changed

// File: rtl/ram_unit_pkg.sv
// Shared widths and loader FSM encoding for the program-loadable RAM unit.
package ram_unit_pkg;

   localparam int unsigned AW_DEF = 3;
   localparam int unsigned DW_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/ram_loader_fsm.sv
// Loader sequencer: tracks IDLE/LOAD/DONE and the loader write pointer.
module ram_loader_fsm
   import ram_unit_pkg::*;
#(
   parameter int unsigned AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          prog,
   input  logic          pvalid,
   output state_e        state,
   output logic          pready,
   output logic          pdone,
   output logic [AW-1:0] paddr,
   output logic          hs_c
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] paddr_q, paddr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         paddr_q <= '0;
      end else begin
         state_q <= state_d;
         paddr_q <= paddr_d;
      end
   end

   // Pointer only moves on a handshake; it is parked at 0 outside LOAD.
   always_comb begin
      state_d = state_q;
      paddr_d = paddr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (prog) begin
               state_d = ST_LOAD;
               paddr_d = '0;
            end
         end
         ST_LOAD: begin
            if (!prog) begin
               state_d = ST_IDLE;
               paddr_d = '0;
            end else if (pvalid) begin
               if (paddr_q == LAST_ADDR) begin
                  state_d = ST_DONE;
                  paddr_d = '0;
               end else begin
                  paddr_d = paddr_q + AW'(1);
               end
            end
         end
         ST_DONE: begin
            if (!prog) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            paddr_d = '0;
         end
      endcase
   end

   always_comb begin
      pready = 1'b0;
      pdone  = 1'b0;
      hs_c   = 1'b0;
      if (state_q == ST_LOAD) begin
         pready = 1'b1;
         hs_c   = pvalid;
      end
      if (state_q == ST_DONE) begin
         pdone = 1'b1;
      end
   end

   assign state = state_q;
   assign paddr = paddr_q;

endmodule

// File: rtl/ram_unit.sv
// RAM with a CPU port (active-low strobes) and a streaming program loader.
module ram_unit
   import ram_unit_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [AW-1:0] ABUS,
   input  logic          WEn,
   input  logic          OEn,
   input  logic [DW-1:0] DIN,
   output logic [DW-1:0] DOUT,
   input  logic          PROG,
   input  logic [DW-1:0] PDATA,
   input  logic          PVALID,
   output logic          PREADY,
   output logic [AW-1:0] PADDR,
   output logic          PDONE
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];

   state_e        state;
   logic          hs_c;
   logic          cpu_we_c;

   ram_loader_fsm #(.AW(AW)) u_loader (
      .clk    (CLK),
      .rst    (RST),
      .prog   (PROG),
      .pvalid (PVALID),
      .state  (state),
      .pready (PREADY),
      .pdone  (PDONE),
      .paddr  (PADDR),
      .hs_c   (hs_c)
   );

   // CPU may only write when idle and no load is being requested on this edge.
   assign cpu_we_c = !WEn && (state == ST_IDLE) && !PROG;

   always_comb begin
      mem_d = mem_q;
      if (hs_c) begin
         mem_d[PADDR] = PDATA;
      end else if (cpu_we_c) begin
         mem_d[ABUS] = DIN;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      DOUT = '0;
      if (!OEn && (state == ST_IDLE)) begin
         DOUT = mem_q[ABUS];
      end
   end

endmodule
